// File: rtl/snake_pkg.sv
// Shared definitions for the snake field: cell codes, apple-spawner FSM states and LFSR constants.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package snake_pkg;

  // Field cell codes, 3 bits per cell
  localparam logic [2:0] CELL_EMPTY = 3'd0;
  localparam logic [2:0] CELL_SNAKE = 3'd1;
  localparam logic [2:0] CELL_HEAD  = 3'd2;
  localparam logic [2:0] CELL_APPLE = 3'd3;

  // Apple spawner FSM states
  typedef enum logic [2:0] {
    SP_IDLE  = 3'd0,
    SP_DRAW  = 3'd1,
    SP_CHECK = 3'd2,
    SP_DONE  = 3'd3,
    SP_FAIL  = 3'd4
  } spawn_state_e;

  // Fibonacci taps 16,14,13,11 expressed as a mask over bits [15:0]
  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_INIT_DEFAULT = 16'hACE1;

endpackage

// File: rtl/apple_spawner_if.sv
// Bundle between the apple spawner, the possible_apple lookup stage and the game FSM.
// Latency: none (wiring only); optional tries_used exists when APPLE_SPAWN_STATS_EN is defined.
// Backpressure: apple_valid holds until apple_ack; spawn_req is not queued while busy.
interface apple_spawner_if #(
  parameter logic [7:0] SIZE_X     = 8'd10,
  parameter logic [7:0] SIZE_Y     = 8'd10,
  parameter int         FIELD_SIZE = int'(SIZE_X) * int'(SIZE_Y) * 3,
  parameter int         SBITS      = $clog2(int'(SIZE_X) * int'(SIZE_Y)),
  parameter int         MAX_TRIES  = 8
);
  localparam int NCELLS = int'(SIZE_X) * int'(SIZE_Y);
  localparam int TW     = $clog2(MAX_TRIES + 1);

  logic                      spawn_req;
  logic [FIELD_SIZE-1:0]     field;
  logic [SBITS*NCELLS-1:0]   sets_seed;
  logic [SBITS-1:0]          seed;
  logic [SBITS-1:0]          apple_pos;
  logic                      apple_valid;
  logic                      apple_ack;
  logic                      apple_fail;
  logic                      busy;
`ifdef APPLE_SPAWN_STATS_EN
  logic [TW-1:0]             tries_used;

  modport master (
    input  spawn_req, field, sets_seed, apple_ack,
    output seed, apple_pos, apple_valid, apple_fail, busy, tries_used
  );
  modport slave (
    output spawn_req, field, sets_seed, apple_ack,
    input  seed, apple_pos, apple_valid, apple_fail, busy, tries_used
  );
`else
  modport master (
    input  spawn_req, field, sets_seed, apple_ack,
    output seed, apple_pos, apple_valid, apple_fail, busy
  );
  modport slave (
    output spawn_req, field, sets_seed, apple_ack,
    input  seed, apple_pos, apple_valid, apple_fail, busy
  );
`endif

endinterface

// File: rtl/apple_lfsr.sv
// Free-running Fibonacci LFSR supplying the random draw for apple placement.
// Latency: new value every cycle, registered output.
// Backpressure: none; it never stalls.
module apple_lfsr
  import snake_pkg::*;
#(
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] LFSR_INIT = LFSR_W'(LFSR_INIT_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [LFSR_W-1:0] q
);

  localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(LFSR_TAPS);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;
  logic              fb;

  // Next state: shift left, feed back XOR of the tapped bits
  always_comb begin
    fb     = ^(lfsr_q & TAPS);
    lfsr_d = {lfsr_q[LFSR_W-2:0], fb};
  end

  // State register, restarts from the seed on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= LFSR_INIT;
    else        lfsr_q <= lfsr_d;
  end

  assign q = lfsr_q;

endmodule

// File: rtl/apple_spawner.sv
// Apple placement controller: draws a random index, checks the looked-up cell is empty, retries up to MAX_TRIES.
// Latency: 2 cycles per in-range attempt, 1 per out-of-range draw; apple_fail is a one-cycle pulse.
// Backpressure: apple_valid holds until apple_ack; spawn_req only sampled in IDLE. Optional: APPLE_SPAWN_STATS_EN.
module apple_spawner
  import snake_pkg::*;
#(
  parameter logic [7:0]        SIZE_X     = 8'd10,
  parameter logic [7:0]        SIZE_Y     = 8'd10,
  parameter int                FIELD_SIZE = int'(SIZE_X) * int'(SIZE_Y) * 3,
  parameter int                SBITS      = $clog2(int'(SIZE_X) * int'(SIZE_Y)),
  parameter int                LFSR_W     = 16,
  parameter logic [LFSR_W-1:0] LFSR_INIT  = LFSR_W'(LFSR_INIT_DEFAULT),
  parameter int                MAX_TRIES  = 8
) (
  input logic           clk,
  input logic           rst_n,
  apple_spawner_if.master bus
);

  localparam int             NCELLS   = FIELD_SIZE / 3;
  localparam int             TW       = $clog2(MAX_TRIES + 1);
  localparam logic [TW-1:0]  MAX_T    = TW'(MAX_TRIES);
  localparam logic [SBITS:0] NCELLS_W = (SBITS + 1)'(NCELLS);

  localparam logic [2:0] ST_IDLE  = 3'(SP_IDLE);
  localparam logic [2:0] ST_DRAW  = 3'(SP_DRAW);
  localparam logic [2:0] ST_CHECK = 3'(SP_CHECK);
  localparam logic [2:0] ST_DONE  = 3'(SP_DONE);
  localparam logic [2:0] ST_FAIL  = 3'(SP_FAIL);

  logic [2:0]        state_q, state_d;
  logic [TW-1:0]     tries_q, tries_d, tries_inc;
  logic [SBITS-1:0]  seed_q, seed_d;
  logic [SBITS-1:0]  pos_q, pos_d;
  logic              valid_q, valid_d;
  logic              fail_q, fail_d;

  logic [LFSR_W-1:0] lfsr;
  logic [SBITS-1:0]  draw;
  logic              draw_ok;
  logic              unused_lfsr_hi;

  logic [SBITS-1:0]  cand_arr [NCELLS];
  logic [2:0]        cell_arr [NCELLS];
  logic [SBITS-1:0]  cand;
  logic              cand_free;

  apple_lfsr #(
    .LFSR_W    (LFSR_W),
    .LFSR_INIT (LFSR_INIT)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (lfsr)
  );

  assign draw           = lfsr[SBITS-1:0];
  assign draw_ok        = {1'b0, draw} < NCELLS_W;
  assign unused_lfsr_hi = ^lfsr[LFSR_W-1:SBITS];
  assign tries_inc      = tries_q + TW'(1);

  // Split the packed lookup vector and field into per-cell entries
  always_comb begin
    for (int i = 0; i < NCELLS; i++) begin
      cand_arr[i] = bus.sets_seed[i*SBITS +: SBITS];
      cell_arr[i] = bus.field[i*3 +: 3];
    end
  end

  // Candidate for the registered seed and whether its cell is free; out-of-range indices count as occupied
  always_comb begin
    cand      = '0;
    cand_free = 1'b0;
    if ({1'b0, seed_q} < NCELLS_W) begin
      cand = cand_arr[seed_q];
      if ({1'b0, cand} < NCELLS_W) cand_free = (cell_arr[cand] == CELL_EMPTY);
    end
  end

  // Spawn FSM: draw, check, retry until success or the try budget is spent
  always_comb begin
    state_d = state_q;
    tries_d = tries_q;
    seed_d  = seed_q;
    pos_d   = pos_q;
    valid_d = valid_q;
    fail_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.spawn_req) begin
          state_d = ST_DRAW;
          tries_d = '0;
        end
      end
      ST_DRAW: begin
        tries_d = tries_inc;
        if (draw_ok) begin
          seed_d  = draw;
          state_d = ST_CHECK;
        end else if (tries_inc >= MAX_T) begin
          state_d = ST_FAIL;
          fail_d  = 1'b1;
        end
      end
      ST_CHECK: begin
        if (cand_free) begin
          pos_d   = cand;
          valid_d = 1'b1;
          state_d = ST_DONE;
        end else if (tries_q < MAX_T) begin
          state_d = ST_DRAW;
        end else begin
          state_d = ST_FAIL;
          fail_d  = 1'b1;
        end
      end
      ST_DONE: begin
        // A spawn_req arriving with the ack is deliberately dropped
        if (bus.apple_ack) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_FAIL: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      tries_q <= '0;
      seed_q  <= '0;
      pos_q   <= '0;
      valid_q <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tries_q <= tries_d;
      seed_q  <= seed_d;
      pos_q   <= pos_d;
      valid_q <= valid_d;
      fail_q  <= fail_d;
    end
  end

  assign bus.seed        = seed_q;
  assign bus.apple_pos   = pos_q;
  assign bus.apple_valid = valid_q;
  assign bus.apple_fail  = fail_q;
  assign bus.busy        = (state_q != ST_IDLE);

`ifdef APPLE_SPAWN_STATS_EN
  logic [TW-1:0] stats_q;
  logic          spawn_end;

  assign spawn_end = (state_q == ST_CHECK && state_d == ST_DONE) || fail_d;

  // Capture the attempt count of each finished spawn
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         stats_q <= '0;
    else if (spawn_end) stats_q <= tries_d;
  end

  assign bus.tries_used = stats_q;
`endif

endmodule

// File: tb/tb_apple_spawner.sv
// Self-checking bench for apple_spawner: table of spawn scenarios scored against an LFSR/lookup model.
// Latency: checks cycle-exact result timing relative to the sampled spawn_req.
// Backpressure: exercises apple_ack holding, ack outside DONE, and spawn_req colliding with ack.
module tb_apple_spawner;

  localparam int N  = 100;
  localparam int SB = 7;
  localparam int MT = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  apple_spawner_if #(.SIZE_X(8'd10), .SIZE_Y(8'd10), .MAX_TRIES(MT)) bus ();

  apple_spawner #(
    .SIZE_X    (8'd10),
    .SIZE_Y    (8'd10),
    .LFSR_W    (16),
    .LFSR_INIT (16'hACE1),
    .MAX_TRIES (MT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int fail;
    int pos;
    int seed;
    int lat;
    int tries;
  } exp_t;

  typedef struct {
    int mode;      // 0 all empty, 1 all occupied, 2 only cell 57 empty, 3 random
    int gap;       // idle cycles before the request
    int exp_fail;  // -1: decided by the model only
    int exp_pos;   // -1: decided by the model only; else required pos on success
  } vec_t;

  int   n_chk = 0;
  int   n_err = 0;
  exp_t sb[$];
  logic [2:0] cells [N];
  int   lk [N];
  logic [15:0] m_lfsr;
  int   last_pos;
  int   last_fail;

  function automatic logic [15:0] lf_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Reference LFSR tracking the DUT's free-running generator
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= lf_next(m_lfsr);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Field model plus the lookup stage: nearest free cell at or below the index, else the top cell
  task automatic set_field(input int mode);
    int j;
    for (int i = 0; i < N; i++) begin
      case (mode)
        0:       cells[i] = 3'd0;
        1:       cells[i] = 3'd1;
        2:       cells[i] = (i == 57) ? 3'd0 : 3'd1;
        default: cells[i] = ($urandom_range(0, 2) == 0) ? 3'd0 : 3'd2;
      endcase
    end
    for (int i = 0; i < N; i++) begin
      j = i;
      while (j >= 0 && cells[j] != 3'd0) j--;
      lk[i] = (j < 0) ? N - 1 : j;
      bus.field[i*3 +: 3]      = cells[i];
      bus.sets_seed[i*SB +: SB] = SB'(lk[i]);
    end
  endtask

  function automatic exp_t predict(input logic [15:0] cur);
    exp_t r;
    logic [15:0] l;
    int d, c;
    bit done;
    r = '{default: 0};
    l = lf_next(cur);
    done = 1'b0;
    while (!done) begin
      r.lat++;
      r.tries++;
      d = int'(l[6:0]);
      l = lf_next(l);
      if (d < N) begin
        r.seed = d;
        r.lat++;
        l = lf_next(l);
        c = lk[d];
        if (cells[c] == 3'd0) begin
          r.pos = c;
          done = 1'b1;
        end else if (r.tries >= MT) begin
          r.fail = 1;
          done = 1'b1;
        end
      end else if (r.tries >= MT) begin
        r.fail = 1;
        done = 1'b1;
      end
    end
    return r;
  endfunction

  // Drive a request at a negedge and record its expected outcome
  task automatic req_push();
    @(negedge clk);
    bus.spawn_req = 1'b1;
    sb.push_back(predict(m_lfsr));
  endtask

  // Idle until the next draw will be in range (bounded)
  task automatic wait_inrange();
    logic [15:0] nx;
    for (int k = 0; k < 64; k++) begin
      nx = lf_next(m_lfsr);
      if (int'(nx[6:0]) < N) return;
      @(negedge clk);
    end
    chk("wait_inrange_timeout", 0, 1);
  endtask

  task automatic wait_result(input string tag, input bit keep_req, input int hold, input bit do_ack);
    int   edges;
    bit   seen;
    exp_t e;
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < 80) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (!keep_req) bus.spawn_req = 1'b0;
      seen = bus.apple_valid || bus.apple_fail;
    end
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 0, 1);
      return;
    end
    e = sb.pop_front();
    if (!seen) begin
      chk({tag, "_timeout"}, 0, 1);
      return;
    end
    last_pos  = int'(bus.apple_pos);
    last_fail = int'(bus.apple_fail);
    chk({tag, "_latency"}, edges - 1, e.lat);
    chk({tag, "_fail"}, int'(bus.apple_fail), e.fail);
    chk({tag, "_valid"}, int'(bus.apple_valid), 1 - e.fail);
`ifdef APPLE_SPAWN_STATS_EN
    chk({tag, "_tries_used"}, int'(bus.tries_used), e.tries);
`endif
    if (e.fail != 0) begin
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_fail_pulse_len"}, int'(bus.apple_fail), 0);
      chk({tag, "_busy_after_fail"}, int'(bus.busy), 0);
    end else begin
      chk({tag, "_pos"}, int'(bus.apple_pos), e.pos);
      chk({tag, "_seed"}, int'(bus.seed), e.seed);
      chk({tag, "_busy_done"}, int'(bus.busy), 1);
      repeat (hold) @(negedge clk);
      chk({tag, "_valid_hold"}, int'(bus.apple_valid), 1);
      if (do_ack) begin
        bus.apple_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.apple_ack = 1'b0;
        chk({tag, "_valid_clear"}, int'(bus.apple_valid), 0);
        chk({tag, "_busy_idle"}, int'(bus.busy), 0);
      end
    end
  endtask

  vec_t vecs [8];
  bit   any_fail;

  initial begin
    vecs[0] = '{0, 0, -1, -1};
    vecs[1] = '{0, 3, -1, -1};
    vecs[2] = '{1, 0,  1, -1};
    vecs[3] = '{2, 0, -1, 57};
    vecs[4] = '{2, 5, -1, 57};
    vecs[5] = '{3, 2, -1, -1};
    vecs[6] = '{1, 4,  1, -1};
    vecs[7] = '{2, 1, -1, 57};

    rst_n         = 1'b0;
    bus.spawn_req = 1'b0;
    bus.apple_ack = 1'b0;
    bus.field     = '0;
    bus.sets_seed = '0;
    set_field(0);
    repeat (2) @(negedge clk);
    chk("rst_seed", int'(bus.seed), 0);
    chk("rst_pos", int'(bus.apple_pos), 0);
    chk("rst_valid", int'(bus.apple_valid), 0);
    chk("rst_fail", int'(bus.apple_fail), 0);
    chk("rst_busy", int'(bus.busy), 0);
`ifdef APPLE_SPAWN_STATS_EN
    chk("rst_tries_used", int'(bus.tries_used), 0);
`endif
    rst_n = 1'b1;

    // Table-driven spawns
    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      set_field(vecs[v].mode);
      repeat (vecs[v].gap) @(negedge clk);
      req_push();
      wait_result($sformatf("vec%0d", v), 1'b0, 2, 1'b1);
      if (vecs[v].exp_fail >= 0) chk($sformatf("vec%0d_tbl_fail", v), last_fail, vecs[v].exp_fail);
      if (vecs[v].exp_pos >= 0 && last_fail == 0) chk($sformatf("vec%0d_tbl_pos", v), last_pos, vecs[v].exp_pos);
    end

    // Ack in IDLE is ignored
    @(negedge clk);
    set_field(0);
    bus.apple_ack = 1'b1;
    repeat (2) @(negedge clk);
    chk("ack_idle_valid", int'(bus.apple_valid), 0);
    chk("ack_idle_busy", int'(bus.busy), 0);
    bus.apple_ack = 1'b0;

    // Ack during DRAW and CHECK is ignored; valid survives into DONE
    wait_inrange();
    bus.spawn_req = 1'b1;
    sb.push_back(predict(m_lfsr));
    @(posedge clk);
    @(negedge clk);
    bus.spawn_req = 1'b0;
    bus.apple_ack = 1'b1;
    chk("ack_draw_valid", int'(bus.apple_valid), 0);
    @(posedge clk);
    @(negedge clk);
    chk("ack_check_valid", int'(bus.apple_valid), 0);
    chk("ack_check_busy", int'(bus.busy), 1);
    @(posedge clk);
    @(negedge clk);
    bus.apple_ack = 1'b0;
    chk("ack_early_done_valid", int'(bus.apple_valid), 1);
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("ack_early_pos", int'(bus.apple_pos), e.pos);
    end
    @(posedge clk);
    @(negedge clk);
    chk("ack_early_valid_kept", int'(bus.apple_valid), 1);
    bus.apple_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.apple_ack = 1'b0;
    chk("ack_early_cleared", int'(bus.apple_valid), 0);

    // spawn_req held through DONE with ack: request dropped, new spawn only from IDLE
    req_push();
    wait_result("held", 1'b1, 1, 1'b0);
    bus.apple_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.apple_ack = 1'b0;
    chk("held_valid_clear", int'(bus.apple_valid), 0);
    chk("held_idle", int'(bus.busy), 0);
    sb.push_back(predict(m_lfsr));
    wait_result("held_respawn", 1'b0, 0, 1'b1);

    // spawn_req only together with ack in DONE: dropped
    req_push();
    wait_result("drop", 1'b0, 0, 1'b0);
    bus.apple_ack = 1'b1;
    bus.spawn_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.apple_ack = 1'b0;
    bus.spawn_req = 1'b0;
    chk("drop_valid_clear", int'(bus.apple_valid), 0);
    @(posedge clk);
    @(negedge clk);
    chk("drop_not_started", int'(bus.busy), 0);

    // Reset while in CHECK
    wait_inrange();
    bus.spawn_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.spawn_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_busy_before", int'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_seed", int'(bus.seed), 0);
    chk("rst_mid_pos", int'(bus.apple_pos), 0);
    chk("rst_mid_valid", int'(bus.apple_valid), 0);
    chk("rst_mid_busy", int'(bus.busy), 0);
    any_fail = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (bus.apple_fail) any_fail = 1'b1;
    end
    chk("rst_mid_no_fail", int'(any_fail), 0);
    rst_n = 1'b1;
    req_push();
    wait_result("after_rst", 1'b0, 0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
